// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one sequential multiplier among N_REQ clients.
// It grants one client, issues a Start pulse, waits out the Ready handshake, and returns the product with a done pulse.
module mult_arbiter #(
    parameter int DP_WIDTH = 5,
    parameter int N_REQ    = 4
) (
    input  logic                      clock,
    input  logic                      reset_b,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DP_WIDTH-1:0] req_mcand,
    input  logic [N_REQ*DP_WIDTH-1:0] req_mplier,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [2*DP_WIDTH-1:0]     result,
    output logic                      busy,
    output logic                      mult_start,
    output logic [DP_WIDTH-1:0]       mult_mcand,
    output logic [DP_WIDTH-1:0]       mult_mplier,
    input  logic [2*DP_WIDTH-1:0]     mult_product,
    input  logic                      mult_ready
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t                          state;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                win_idx;
    logic [PTR_W-1:0]                hi_idx;
    logic [PTR_W-1:0]                nxt_ptr;
    logic                            win_vld;
    logic                            hi_vld;
    logic [N_REQ-1:0][DP_WIDTH-1:0]  mcand_v;
    logic [N_REQ-1:0][DP_WIDTH-1:0]  mplier_v;

    assign mcand_v  = req_mcand;
    assign mplier_v = req_mplier;

    // Wrapping scan: lowest requester at or above rr_ptr wins; otherwise the lowest requester overall.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        hi_vld  = 1'b0;
        hi_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(i);
            end
            if (req[i] && (PTR_W'(i) >= rr_ptr)) begin
                hi_vld = 1'b1;
                hi_idx = PTR_W'(i);
            end
        end
        if (hi_vld)
            win_idx = hi_idx;
    end

    assign nxt_ptr = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            result      <= '0;
            busy        <= 1'b0;
            mult_start  <= 1'b0;
            mult_mcand  <= '0;
            mult_mplier <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_ready && win_vld) begin
                        grant       <= N_REQ'(1) << win_idx;
                        mult_mcand  <= mcand_v[win_idx];
                        mult_mplier <= mplier_v[win_idx];
                        rr_ptr      <= nxt_ptr;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start <= 1'b1;
                    state      <= WAIT_BUSY;
                end
                // Ready is still high while Start is being sampled, so wait for it to fall.
                WAIT_BUSY: begin
                    mult_start <= 1'b0;
                    if (!mult_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mult_ready) begin
                        result <= mult_product;
                        done   <= grant;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
